// File: rtl/relu_maxpool_requant_pkg.sv
// Shared types and constants for the ReLU / requantise / 2x2 max-pool output stage.
package relu_maxpool_requant_pkg;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned AccWidth  = DataWidth + 12;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Largest non-negative signed activation for a given width.
  function automatic int unsigned act_max(input int unsigned dw);
    return (32'd1 << (dw - 1)) - 32'd1;
  endfunction

  localparam int unsigned ActMax = act_max(DataWidth);

endpackage

// File: rtl/relu_requant.sv
// Combinational ReLU, arithmetic right-shift requantisation and saturation to a
// non-negative signed activation.
module relu_requant
  import relu_maxpool_requant_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth
) (
  input  logic [DATA_WIDTH+11:0] acc,
  input  logic [3:0]             shift,
  output logic [DATA_WIDTH-1:0]  act
);

  localparam int unsigned AW = DATA_WIDTH + 12;
  localparam logic [AW-1:0] SatMax = AW'(act_max(DATA_WIDTH));

  logic [AW-1:0] relu;
  logic [AW-1:0] shifted;

  always_comb begin
    relu    = acc[AW-1] ? '0 : acc;
    shifted = relu >> shift;
    act     = (shifted > SatMax) ? SatMax[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/relu_maxpool_requant.sv
// Raster-order ReLU/requant followed by 2x2 stride-2 max pooling; one pooled
// activation with its coordinates per completed window.
module relu_maxpool_requant
  import relu_maxpool_requant_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth,
  parameter int unsigned MAX_WIDTH  = 26
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4:0]             fmap_width,
  input  logic [4:0]             fmap_height,
  input  logic [3:0]             shift,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH+11:0] in_data,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [3:0]             out_x,
  output logic [3:0]             out_y,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned Depth = MAX_WIDTH / 2;
  localparam int unsigned IdxW  = (Depth > 1) ? $clog2(Depth) : 1;

  state_e state_q, state_d;

  logic [4:0]            width_q, height_q;
  logic [3:0]            shift_q;
  logic [4:0]            col_q, row_q;
  logic [DATA_WIDTH-1:0] hmax_q;
  logic [DATA_WIDTH-1:0] linebuf_q [Depth];
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [3:0]            out_x_q, out_y_q;

  logic [DATA_WIDTH-1:0] act;
  logic [DATA_WIDTH-1:0] pair_max;
  logic [DATA_WIDTH-1:0] win_max;
  logic [IdxW-1:0]       lb_idx;
  logic                  accept, col_last, row_last, last_pix;
  logic                  hmax_we, lb_we, emit;

  relu_requant #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_relu_requant (
    .acc   (in_data),
    .shift (shift_q),
    .act   (act)
  );

  // A start in the same cycle takes priority and drops the pixel.
  always_comb begin
    accept   = (state_q == StRun) && in_valid && !start;
    col_last = (col_q == width_q - 5'd1);
    row_last = (row_q == height_q - 5'd1);
    last_pix = accept && col_last && row_last;
    lb_idx   = IdxW'(col_q >> 1);
    pair_max = (act > hmax_q) ? act : hmax_q;
    win_max  = (linebuf_q[lb_idx] > pair_max) ? linebuf_q[lb_idx] : pair_max;
    // Odd-W last column and odd-H last row fall through with no writes.
    hmax_we  = accept && !col_q[0] && !col_last;
    lb_we    = accept && col_q[0] && !row_q[0] && !row_last;
    emit     = accept && col_q[0] && row_q[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StRun;
    end else if (state_q == StRun && last_pix) begin
      state_d = StDone;
    end
  end

  always_comb begin
    busy = (state_q == StRun);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      width_q     <= '0;
      height_q    <= '0;
      shift_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      hmax_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      for (int i = 0; i < Depth; i++) begin
        linebuf_q[i] <= '0;
      end
    end else if (start) begin
      width_q     <= fmap_width;
      height_q    <= fmap_height;
      shift_q     <= shift;
      col_q       <= '0;
      row_q       <= '0;
      hmax_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= emit;
      if (accept) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + 5'd1;
        end else begin
          col_q <= col_q + 5'd1;
        end
      end
      if (hmax_we) begin
        hmax_q <= act;
      end
      if (lb_we) begin
        linebuf_q[lb_idx] <= pair_max;
      end
      if (emit) begin
        out_data_q <= win_max;
        out_x_q    <= 4'(col_q >> 1);
        out_y_q    <= 4'(row_q >> 1);
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;

endmodule
